// File: rtl/branch_predictor_pkg.sv
// Shared encodings and counter helpers for the branch predictor.
package bp_pkg;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;

    // Weakly not-taken starting value; counters are at most 4 bits wide.
    function automatic logic [3:0] cntInit(input int cntW);
        return 4'((1 << (cntW - 1)) - 1);
    endfunction

    function automatic logic [3:0] cntNext(input logic [3:0] cnt, input logic up, input int cntW);
        logic [3:0] cntMax;
        cntMax = 4'((1 << cntW) - 1);
        if (up)
            return (cnt == cntMax) ? cnt : cnt + 4'd1;
        return (cnt == 4'd0) ? cnt : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Decode/execute connection between the pipeline and the branch predictor.
interface branch_predictor_if;
    logic [31:0] pcD;
    logic        branchD;
    logic        stallD;
    logic        stallE;
    logic        flushE;
    logic        branchE;
    logic        actual_takenE;
    logic        predictD;
    logic        predictE;
    logic        predict_wrongE;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output pcD, branchD, stallD, stallE, flushE, branchE, actual_takenE,
        input  predictD, predictE, predict_wrongE, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pcD, branchD, stallD, stallE, flushE, branchE, actual_takenE,
        output predictD, predictE, predict_wrongE, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_pht.sv
// Pattern history table: async read, saturating sync update, reset to weakly not-taken.
module bp_pht
    import bp_pkg::*;
#(
    parameter int PHT_IDX_W = 6,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PHT_IDX_W-1:0] rdIdx,
    output logic [CNT_W-1:0]     rdCnt,
    input  logic                 wrEn,
    input  logic [PHT_IDX_W-1:0] wrIdx,
    input  logic                 wrTaken
);

    localparam int         ENTRIES = 1 << PHT_IDX_W;
    localparam logic [3:0] INIT4   = cntInit(CNT_W);

    logic [CNT_W-1:0] cnt [ENTRIES];
    logic [3:0]       nxt4;

    assign rdCnt = cnt[rdIdx];
    assign nxt4  = cntNext(4'(cnt[wrIdx]), wrTaken, CNT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt[i] <= INIT4[CNT_W-1:0];
        end else if (wrEn) begin
            cnt[wrIdx] <= nxt4[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare predictor with speculative GHR and misprediction repair.
// Optional counters enabled by BRANCH_PREDICTOR_STATS_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PHT_IDX_W  = 6,
    parameter int CNT_W      = 2,
    parameter int GHR_W      = 6,
    parameter int INDEX_MODE = BP_GSHARE
) (
    input logic                clk,
    input logic                rst,
    branch_predictor_if.slave  bp
);

    logic [PHT_IDX_W-1:0] baseIdx, idxD, idxE;
    logic [GHR_W-1:0]     ghr, ghrE;
    logic [CNT_W-1:0]     cntD;
    logic                 predictE;
    logic                 wrongE;
    logic                 unusedBits;

    assign baseIdx = bp.pcD[PHT_IDX_W+1:2];

    generate
        if (INDEX_MODE == BP_GSHARE) begin : gGshare
            assign idxD = baseIdx ^ PHT_IDX_W'(ghr);
        end else begin : gBimodal
            assign idxD = baseIdx;
        end
    endgenerate

    bp_pht #(.PHT_IDX_W(PHT_IDX_W), .CNT_W(CNT_W)) uPht (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (idxD),
        .rdCnt   (cntD),
        .wrEn    (bp.branchE & ~bp.stallE),
        .wrIdx   (idxE),
        .wrTaken (bp.actual_takenE)
    );

    assign bp.predictD       = bp.branchD & cntD[CNT_W-1];
    assign bp.predictE       = predictE;
    assign wrongE            = bp.branchE & (predictE != bp.actual_takenE);
    assign bp.predict_wrongE = wrongE;

    // Repair wins over a same-cycle decode shift: that decode branch is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (wrongE & ~bp.stallE)
            ghr <= {ghrE[GHR_W-2:0], bp.actual_takenE};
        else if (bp.branchD & ~bp.stallD & ~wrongE)
            ghr <= {ghr[GHR_W-2:0], bp.predictD};
    end

    always_ff @(posedge clk) begin
        if (rst | bp.flushE) begin
            idxE     <= '0;
            ghrE     <= '0;
            predictE <= 1'b0;
        end else if (~bp.stallE) begin
            idxE     <= idxD;
            ghrE     <= ghr;
            predictE <= bp.predictD;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] statBranches, statMispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else begin
            if (bp.branchE & ~bp.stallE)
                statBranches <= statBranches + 32'd1;
            if (wrongE & ~bp.stallE)
                statMispredicts <= statMispredicts + 32'd1;
        end
    end

    assign bp.stat_branches    = statBranches;
    assign bp.stat_mispredicts = statMispredicts;
`else
    assign bp.stat_branches    = '0;
    assign bp.stat_mispredicts = '0;
`endif

    assign unusedBits = ^{bp.pcD[31:PHT_IDX_W+2], bp.pcD[1:0], ghrE[GHR_W-1]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed checks of bimodal and gshare predictor instances sharing one clock/reset.
module tb_branch_predictor;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nAsserts = 0;
    int   nFails   = 0;
    int   expBr, expMis;

    always #5 clk = ~clk;

    branch_predictor_if ifBi ();
    branch_predictor_if ifGs ();

    branch_predictor #(.INDEX_MODE(BP_BIMODAL)) dutBi (.clk(clk), .rst(rst), .bp(ifBi));
    branch_predictor #(.INDEX_MODE(BP_GSHARE))  dutGs (.clk(clk), .rst(rst), .bp(ifGs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        ifBi.pcD = 32'h0; ifBi.branchD = 0; ifBi.stallD = 0; ifBi.stallE = 0;
        ifBi.flushE = 0; ifBi.branchE = 0; ifBi.actual_takenE = 0;
        ifGs.pcD = 32'h0; ifGs.branchD = 0; ifGs.stallD = 0; ifGs.stallE = 0;
        ifGs.flushE = 0; ifGs.branchE = 0; ifGs.actual_takenE = 0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idleAll();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_predictE", 32'(ifBi.predictE), 32'd0);
        chk("rst_wrongE", 32'(ifBi.predict_wrongE), 32'd0);
        chk("rst_ghrGs", 32'(dutGs.ghr), 32'd0);
        chk("rst_statBr", ifBi.stat_branches, 32'd0);
        chk("rst_statMis", ifBi.stat_mispredicts, 32'd0);

        // Bimodal: first lookup at pc 0x00400010 -> index 4, weakly not-taken
        ifBi.pcD = 32'h0040_0010; ifBi.branchD = 1;
        #1;
        chk("bi_predictD_init", 32'(ifBi.predictD), 32'd0);
        chk("bi_pht4_init", 32'(dutBi.uPht.cnt[4]), 32'd1);
        tick();
        chk("bi_predictE_0", 32'(ifBi.predictE), 32'd0);

        ifBi.branchE = 1; ifBi.actual_takenE = 1;
        #1;
        chk("bi_wrong_taken", 32'(ifBi.predict_wrongE), 32'd1);
        tick();
        chk("bi_pht4_up1", 32'(dutBi.uPht.cnt[4]), 32'd2);
        chk("bi_predictD_up1", 32'(ifBi.predictD), 32'd1);
        tick();
        chk("bi_pht4_up2", 32'(dutBi.uPht.cnt[4]), 32'd3);
        tick();
        chk("bi_pht4_sat", 32'(dutBi.uPht.cnt[4]), 32'd3);
        chk("bi_predictD_sat", 32'(ifBi.predictD), 32'd1);

        ifBi.actual_takenE = 0;
        #1;
        chk("bi_wrong_nt", 32'(ifBi.predict_wrongE), 32'd1);
        tick();
        chk("bi_pht4_down", 32'(dutBi.uPht.cnt[4]), 32'd2);
        chk("bi_predictD_down", 32'(ifBi.predictD), 32'd1);
        idleAll();
        tick();

        // Held branch trains exactly once, on release
        doReset();
        ifBi.pcD = 32'h0040_0010; ifBi.branchD = 1;
        tick();
        ifBi.branchD = 0; ifBi.branchE = 1; ifBi.actual_takenE = 1; ifBi.stallE = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i), 32'(dutBi.uPht.cnt[4]), 32'd1);
        end
        ifBi.stallE = 0;
        tick();
        chk("stall_release", 32'(dutBi.uPht.cnt[4]), 32'd2);
        ifBi.branchE = 0; ifBi.actual_takenE = 0;
        tick();
        chk("stall_once", 32'(dutBi.uPht.cnt[4]), 32'd2);

        // flushE beats stallE
        ifBi.branchD = 1;
        tick();
        chk("flush_pre_predictE", 32'(ifBi.predictE), 32'd1);
        ifBi.flushE = 1; ifBi.stallE = 1;
        tick();
        chk("flush_predictE", 32'(ifBi.predictE), 32'd0);
        idleAll();

        // Gshare: build GHR=000101 with ghrE=000010, predictE=0
        doReset();
        ifGs.pcD = 32'h0040_0010;
        ifGs.branchE = 1; ifGs.actual_takenE = 1;
        tick();
        ifGs.branchE = 0; ifGs.actual_takenE = 0; ifGs.branchD = 1;
        #1;
        chk("gs_predictD_b", 32'(ifGs.predictD), 32'd0);
        tick();
        ifGs.branchD = 0;
        tick();
        ifGs.branchE = 1; ifGs.actual_takenE = 1;
        tick();
        chk("gs_ghr_pre", 32'(dutGs.ghr), 32'b000101);
        chk("gs_ghrE_pre", 32'(dutGs.ghrE), 32'b000010);
        chk("gs_predictE_pre", 32'(ifGs.predictE), 32'd0);
        chk("gs_wrong", 32'(ifGs.predict_wrongE), 32'd1);
        tick();
        chk("gs_ghr_repair", 32'(dutGs.ghr), 32'b000101);

        // Repair vs simultaneous taken-predicted decode branch
        ifGs.branchE = 0; ifGs.actual_takenE = 0; ifGs.branchD = 1;
        #1;
        chk("gs_predictD_nt", 32'(ifGs.predictD), 32'd0);
        tick();
        chk("gs_ghr_spec", 32'(dutGs.ghr), 32'b001010);
        ifGs.pcD = 32'h0040_0028; ifGs.branchE = 1; ifGs.actual_takenE = 1;
        #1;
        chk("gs_predictD_t", 32'(ifGs.predictD), 32'd1);
        chk("gs_wrong2", 32'(ifGs.predict_wrongE), 32'd1);
        tick();
        chk("gs_ghr_prio", 32'(dutGs.ghr), 32'b001011);
        chk("gs_predictE_cap", 32'(ifGs.predictE), 32'd1);
        chk("gs_idxE_cap", 32'(dutGs.idxE), 32'd0);
        idleAll();

        // Stats: 10 resolved branches, 3 taken against a not-taken prediction
        doReset();
        ifBi.pcD = 32'h0040_0100; ifBi.branchE = 1;
        for (int i = 0; i < 10; i++) begin
            ifBi.actual_takenE = (i == 2 || i == 5 || i == 7);
            tick();
        end
        ifBi.branchE = 0; ifBi.actual_takenE = 0;
`ifdef BRANCH_PREDICTOR_STATS_EN
        expBr = 10; expMis = 3;
`else
        expBr = 0; expMis = 0;
`endif
        chk("stat_branches", ifBi.stat_branches, 32'(expBr));
        chk("stat_mispredicts", ifBi.stat_mispredicts, 32'(expMis));
        ifBi.branchE = 1; ifBi.actual_takenE = 1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stat_br_rst", ifBi.stat_branches, 32'd0);
        chk("stat_mis_rst", ifBi.stat_mispredicts, 32'd0);
        chk("ghr_rst_mid", 32'(dutGs.ghr), 32'd0);
        idleAll();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
